// File: rtl/ase_umsg_engine.sv
// UMsg command engine: buffers UMsg commands and emits an optional hint packet
// followed by a delayed data packet on the CCI-P RX0 UMsg channel.
module ase_umsg_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int HINT_DELAY = 8,
    parameter int DATA_DELAY = 16,
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [5:0]            cmd_id,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [63:0]           hint_en,
    output logic                  rx0_umsg_valid,
    input  logic                  rx0_umsg_ready,
    output logic [27:0]           rx0_umsg_hdr,
    output logic [DATA_WIDTH-1:0] rx0_umsg_data,
    output logic                  busy,
    output logic [31:0]           sent_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXD = (HINT_DELAY > DATA_DELAY) ? HINT_DELAY : DATA_DELAY;
    localparam int TW   = (MAXD > 0) ? $clog2(MAXD + 1) : 1;

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] HINT_LOAD  = TW'(HINT_DELAY);
    localparam logic [TW-1:0] DATA_LOAD  = TW'(DATA_DELAY);
    localparam logic [3:0]    RESP_UMSG  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HINT,
        WAITING,
        SEND_DATA
    } state_t;

    function automatic logic [27:0] make_hdr(input logic is_hint, input logic [5:0] id);
        return {2'b00, 1'b0, 5'b0, RESP_UMSG, is_hint, 9'b0, id};
    endfunction

    logic [5:0]            id_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  push;
    logic                  pop;

    state_t                state;
    logic [TW-1:0]         timer;
    logic [5:0]            w_id;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_hold;

    // cmd_ready looks only at the registered count, so a full FIFO refuses a
    // push even on a cycle where the engine pops.
    assign cmd_ready = (count < FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    // NOTE: payload storage has no reset; only pointers and count define which
    // entries are meaningful, and skipping the reset keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr]   <= cmd_id;
            data_mem[wr_ptr] <= cmd_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            w_id           <= '0;
            w_data         <= '0;
            w_hold         <= 1'b0;
            rx0_umsg_valid <= 1'b0;
            rx0_umsg_hdr   <= '0;
            rx0_umsg_data  <= '0;
            sent_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        w_id   <= id_mem[rd_ptr];
                        w_data <= data_mem[rd_ptr];
                        if (hint_en[id_mem[rd_ptr]]) begin
                            state  <= SEND_HINT;
                            timer  <= HINT_LOAD;
                            w_hold <= 1'b0;
                            if (HINT_DELAY == 0) begin
                                rx0_umsg_valid <= 1'b1;
                                rx0_umsg_hdr   <= make_hdr(1'b1, id_mem[rd_ptr]);
                                rx0_umsg_data  <= '0;
                            end
                        end else begin
                            // The extra held cycle stands in for the hint
                            // handshake, so data latency is uniform.
                            state  <= WAITING;
                            timer  <= DATA_LOAD;
                            w_hold <= 1'b1;
                        end
                    end
                end

                SEND_HINT: begin
                    if (rx0_umsg_valid) begin
                        if (rx0_umsg_ready) begin
                            rx0_umsg_valid <= 1'b0;
                            state          <= WAITING;
                            timer          <= DATA_LOAD;
                        end
                    end else begin
                        if (timer != '0) timer <= timer - TW'(1);
                        if (timer <= TW'(1)) begin
                            rx0_umsg_valid <= 1'b1;
                            rx0_umsg_hdr   <= make_hdr(1'b1, w_id);
                            rx0_umsg_data  <= '0;
                        end
                    end
                end

                WAITING: begin
                    if (w_hold) begin
                        w_hold <= 1'b0;
                    end else if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        state          <= SEND_DATA;
                        rx0_umsg_valid <= 1'b1;
                        rx0_umsg_hdr   <= make_hdr(1'b0, w_id);
                        rx0_umsg_data  <= w_data;
                    end
                end

                SEND_DATA: begin
                    if (rx0_umsg_ready) begin
                        rx0_umsg_valid <= 1'b0;
                        sent_count     <= sent_count + 32'd1;
                        state          <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ase_umsg_engine.sv
// Directed bench for ase_umsg_engine: default-delay instance plus a
// zero-delay instance, checked against hand-computed latencies and headers.
module tb_ase_umsg_engine;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [5:0]    cmd_id = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [63:0]   hint_en = '0;
    logic          valid;
    logic          ready = 1'b1;
    logic [27:0]   hdr;
    logic [DW-1:0] data;
    logic          busy;
    logic [31:0]   sent_count;

    logic          cmd_valid_b = 1'b0;
    logic          cmd_ready_b;
    logic [5:0]    cmd_id_b = '0;
    logic [DW-1:0] cmd_data_b = '0;
    logic [63:0]   hint_en_b = '0;
    logic          valid_b;
    logic          ready_b = 1'b1;
    logic [27:0]   hdr_b;
    logic [DW-1:0] data_b;
    logic          busy_b;
    logic [31:0]   sent_count_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e0 = 0;

    ase_umsg_engine dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_data(cmd_data), .hint_en(hint_en),
        .rx0_umsg_valid(valid), .rx0_umsg_ready(ready), .rx0_umsg_hdr(hdr),
        .rx0_umsg_data(data), .busy(busy), .sent_count(sent_count)
    );

    ase_umsg_engine #(.HINT_DELAY(0), .DATA_DELAY(0)) dut_zero (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_id(cmd_id_b),
        .cmd_data(cmd_data_b), .hint_en(hint_en_b),
        .rx0_umsg_valid(valid_b), .rx0_umsg_ready(ready_b), .rx0_umsg_hdr(hdr_b),
        .rx0_umsg_data(data_b), .busy(busy_b), .sent_count(sent_count_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offer one command; e0 becomes the acceptance edge index.
    task automatic push(input bit sel, input logic [5:0] id, input logic [DW-1:0] d);
        @(negedge clk);
        if (sel) begin
            cmd_valid_b = 1'b1; cmd_id_b = id; cmd_data_b = d;
        end else begin
            cmd_valid = 1'b1; cmd_id = id; cmd_data = d;
        end
        @(posedge clk);
        #1;
        e0 = cyc;
        cmd_valid = 1'b0;
        cmd_valid_b = 1'b0;
    endtask

    // Returns the edge index after which valid was first seen, -1 on timeout.
    task automatic wait_valid(input bit sel, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sel ? valid_b : valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int at;
        int eh;
        int bad;
        int acc;
        int k;
        int seen;
        logic [27:0] exp_hdr [6];
        logic [7:0]  exp_lo  [6];

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valid", valid, 0);
        check("rst_hdr", hdr, 0);
        check("rst_data_zero", data == '0, 1);
        check("rst_busy", busy, 0);
        check("rst_sent", sent_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Non-hinted single command
        hint_en = '0;
        ready = 1'b1;
        push(0, 6'd5, {64{8'hA5}});
        wait_valid(0, 100, at);
        check("nohint_lat", at - e0, 19);
        check("nohint_hdr", hdr, 28'h00F0005);
        check("nohint_data", data == {64{8'hA5}}, 1);
        @(posedge clk); @(negedge clk);
        check("nohint_sent", sent_count, 1);
        check("nohint_valid_drop", valid, 0);
        check("nohint_busy", busy, 0);

        // Hinted single command
        hint_en[5] = 1'b1;
        push(0, 6'd5, {64{8'hA5}});
        wait_valid(0, 100, at);
        check("hint_lat", at - e0, 9);
        check("hint_hdr", hdr, 28'h00F8005);
        check("hint_data_zero", data == '0, 1);
        wait_valid(0, 100, at);
        check("hint_data_lat", at - e0, 27);
        check("hint_data_hdr", hdr, 28'h00F0005);
        check("hint_data_data", data == {64{8'hA5}}, 1);
        @(posedge clk); @(negedge clk);
        check("hint_sent", sent_count, 2);

        // Hint held under backpressure; hint_en dropped after the pop
        ready = 1'b0;
        push(0, 6'd5, {64{8'h3C}});
        @(posedge clk);
        #1 hint_en[5] = 1'b0;
        wait_valid(0, 100, at);
        check("bp_hint_lat", at - e0, 9);
        check("bp_hint_hdr", hdr, 28'h00F8005);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(valid && hdr == 28'h00F8005 && data == '0)) bad++;
        end
        check("bp_hint_hold", bad, 0);
        ready = 1'b1;
        eh = cyc + 1;
        wait_valid(0, 100, at);
        check("bp_data_lat", at - eh, 17);
        check("bp_data_hdr", hdr, 28'h00F0005);
        check("bp_data_data", data == {64{8'h3C}}, 1);
        @(posedge clk); @(negedge clk);
        check("bp_sent", sent_count, 3);

        // FIFO fill while the engine holds a hint, then drain in order
        hint_en = '0;
        hint_en[20] = 1'b1;
        ready = 1'b0;
        push(0, 6'd20, {64{8'd20}});
        repeat (2) @(posedge clk);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_id = 6'(21 + i);
            cmd_data = {64{8'(21 + i)}};
            if (cmd_ready) acc++;
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("fill_accepted", acc, 4);
        check("fill_ready_low", cmd_ready, 0);
        check("fill_busy", busy, 1);
        exp_hdr = '{28'h00F8014, 28'h00F0014, 28'h00F0015, 28'h00F0016, 28'h00F0017, 28'h00F0018};
        exp_lo  = '{8'd0, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
        ready = 1'b1;
        k = 0;
        for (int i = 0; i < 500 && k < 6; i++) begin
            @(negedge clk);
            if (valid) begin
                check($sformatf("drain_hdr%0d", k), hdr, exp_hdr[k]);
                check($sformatf("drain_data%0d", k), data[7:0], exp_lo[k]);
                if (k == 5) check("drain_busy_before", busy, 1);
                k++;
            end
        end
        check("drain_count", k, 6);
        @(posedge clk); @(negedge clk);
        check("drain_busy_after", busy, 0);
        check("drain_sent", sent_count, 8);

        // Reset while Waiting with three commands queued
        hint_en = '0;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_id = 6'(30 + i);
            cmd_data = {64{8'(30 + i)}};
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_hdr", hdr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sent", sent_count, 0);
        check("mid_rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check("post_rst_no_pkt", seen, 0);
        check("post_rst_sent", sent_count, 0);

        // Zero-delay instance
        hint_en_b = '0;
        hint_en_b[7] = 1'b1;
        ready_b = 1'b1;
        push(1, 6'd7, {64{8'h77}});
        wait_valid(1, 20, at);
        check("z_hint_lat", at - e0, 1);
        check("z_hint_hdr", hdr_b, 28'h00F8007);
        wait_valid(1, 20, at);
        check("z_data_lat", at - e0, 3);
        check("z_data_hdr", hdr_b, 28'h00F0007);
        check("z_data_data", data_b == {64{8'h77}}, 1);
        @(posedge clk); @(negedge clk);
        push(1, 6'd8, {64{8'h88}});
        wait_valid(1, 20, at);
        check("z_nohint_lat", at - e0, 3);
        check("z_nohint_hdr", hdr_b, 28'h00F0008);
        @(posedge clk); @(negedge clk);
        check("z_sent", sent_count_b, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
